mac_out_buffer: RTL and testbench
=================================

// Module: mac_out_buffer
// PURPOSE
//  Parametrised successor to the MAC output register. Captures accumulator results from the
//  accumulator stage and converts each from ACC_W to OUT_W, with optional saturation.
//  Buffers results in a DEPTH-entry FIFO and presents them downstream over a valid/ready
//  handshake. Sits between the accumulator and the chip output pins / next consumer.
// PARAMETERS
//  ACC_W   16  accumulator result width, signed two's complement; ACC_W >= OUT_W
//  OUT_W   12  output word width, signed two's complement
//  DEPTH   4   FIFO entries; power of two, >= 2
//  SAT_EN  1   1: clamp to OUT_W signed range; 0: keep low OUT_W bits (wrap)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  async active-high reset
//  flush      in   1                  sync clear of FIFO contents (pointers/count)
//  in_valid   in   1                  tout_acc holds a result to load
//  in_ready   out  1                  buffer can accept (not full)
//  tout_acc   in   ACC_W              accumulator result
//  out_valid  out  1                  sum_out holds a valid word
//  out_ready  in   1                  consumer takes sum_out this cycle
//  sum_out    out  OUT_W              head-of-FIFO word
//  count      out  $clog2(DEPTH)+1    occupied entries
//  sat_flag   out  1                  sticky: a loaded value was clamped
//  sat_clr    in   1                  sync clear of sat_flag
// BEHAVIOUR
//  - Reset (async, rst=1): count=0, pointers=0, out_valid=0, sum_out=0, sat_flag=0,
//    in_ready=1. Entries are not required to clear.
//  - push = in_valid & in_ready. pop = out_valid & out_ready. Both are sampled at posedge clk.
//  - in_ready = (count != DEPTH); it is a pure function of registered state, with no
//    combinational path from out_ready. Push is not accepted when full, even on a pop cycle.
//  - Latency: a word pushed at edge N is visible on sum_out with out_valid=1 after edge N
//    (same-cycle write, read next cycle). No fall-through in the push cycle.
//  - out_valid = (count != 0). sum_out = mem[rd_ptr] when out_valid, else 12'd0 (OUT_W zeros).
//    sum_out holds stable while out_valid & !out_ready.
//  - Push and pop together when 0 < count < DEPTH: count unchanged, both pointers advance.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//  - Conversion with SAT_EN=1:
//      v > 2^(OUT_W-1)-1   -> store 2^(OUT_W-1)-1
//      v < -2^(OUT_W-1)    -> store -2^(OUT_W-1)
//      otherwise           -> store v[OUT_W-1:0]
//    With SAT_EN=0: store tout_acc[OUT_W-1:0] and never set sat_flag.
//  - sat_flag sets on the cycle after a push whose value was clamped. A simultaneous
//    set and sat_clr leaves the flag set (set wins). sat_clr alone clears it.
//  - flush (sync) has priority over push and pop: count=0, pointers=0, out_valid=0 next
//    cycle. The push that cycle is dropped. sat_flag is unaffected.
//  - rst asserted mid-transfer drops all buffered data immediately; no partial state remains.
// STRUCTURE
//  - Package mac_pkg: ACC_W/OUT_W defaults, OUT_MAX/OUT_MIN localparam functions of OUT_W,
//    and function clog2 if the toolchain needs it.
//  - Sub-module sat_clamp (combinational, params IN_W, OUT_W, SAT_EN): outputs y[OUT_W-1:0]
//    and clamped. The FIFO storage and control are in-line in mac_out_buffer.
// TESTING  (ACC_W=16, OUT_W=12, DEPTH=4, SAT_EN=1 unless noted)
//  - Reset, then push 16'h0123 with out_ready=0 -> next cycle out_valid=1, sum_out=12'h123,
//    count=1, sat_flag=0.
//  - Push 16'h0900 then 16'hF000 -> entries 12'h7FF and 12'h800; sat_flag=1 and stays set
//    until sat_clr. Repeat with SAT_EN=0 -> 12'h900 and 12'h000, sat_flag stays 0.
//  - Push 4 words with out_ready=0 -> count=4, in_ready=0; a 5th push is ignored. Then
//    out_ready=1 -> words emerge in order, pointers wrap, count returns to 0, sum_out=0.
//  - Steady push+pop every cycle at count=2 for 10 cycles -> count stays 2, data in order,
//    no loss or duplication.
//  - flush with count=3 and push asserted in the same cycle -> next cycle count=0,
//    out_valid=0; the pushed word never appears.
//  - rst pulsed asynchronously between edges with count=2 -> outputs reset immediately;
//    sat_flag=0; the next push behaves as in the first test.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared defaults and signed-range helpers for the MAC output path.
// The width-dependent limits are functions so each parametrised instance derives its own.
package mac_pkg;

    localparam int ACC_W_DEF = 16;
    localparam int OUT_W_DEF = 12;

    // Largest value representable in a w-bit signed word.
    function automatic int out_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit signed word.
    function automatic int out_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational narrowing of a signed word, either saturating or wrapping.
// 'clamped' reports that saturation altered the value.
module sat_clamp
    import mac_pkg::*;
#(
    parameter int IN_W   = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SAT_EN = 1
) (
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y,
    output logic             clamped
);

    localparam logic [OUT_W-1:0] Y_MAX = OUT_W'(out_max(OUT_W));
    localparam logic [OUT_W-1:0] Y_MIN = OUT_W'(out_min(OUT_W));

    // The value fits when every bit from the output sign bit upward matches.
    logic [IN_W-OUT_W:0] upper;
    logic                overflow;

    assign upper    = x[IN_W-1:OUT_W-1];
    assign overflow = !((&upper) || !(|upper));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        clamped = (SAT_EN != 0) && overflow;
        y       = x[OUT_W-1:0];
        if (clamped) begin
            y = x[IN_W-1] ? Y_MIN : Y_MAX;
        end
    end

endmodule

// File: rtl/mac_out_buffer.sv
// Output buffer for the MAC: narrows accumulator results and queues them in a small FIFO
// presented over valid/ready; the sticky sat_flag records any clamped load.
module mac_out_buffer
    import mac_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int DEPTH  = 4,
    parameter int SAT_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ACC_W-1:0]           tout_acc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           sum_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sat_flag,
    input  logic                       sat_clr
);

    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [OUT_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             sat_flag_q, sat_flag_d;

    logic [OUT_W-1:0] conv_word;
    logic             conv_clamped;
    logic             push, pop, wr_en;

    sat_clamp #(
        .IN_W   (ACC_W),
        .OUT_W  (OUT_W),
        .SAT_EN (SAT_EN)
    ) u_sat_clamp (
        .x       (tout_acc),
        .y       (conv_word),
        .clamped (conv_clamped)
    );

    // Handshake status depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign sum_out   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign sat_flag  = sat_flag_q;

    assign push  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    assign wr_en = push & ~flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sat_flag_d = sat_flag_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // A new clamp outranks a same-cycle clear; a push dropped by flush is never loaded.
        if (wr_en && conv_clamped) begin
            sat_flag_d = 1'b1;
        end else if (sat_clr) begin
            sat_flag_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    // NOTE: storage has no reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= conv_word;
        end
    end

endmodule

// File: tb/tb_mac_out_buffer.sv
// Directed bench for mac_out_buffer: a queue scoreboard of expected words plus a sticky
// saturation model, with a second wrapping (SAT_EN=0) instance.
module tb_mac_out_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, sat_clr;
    logic [15:0] tout_acc;
    logic        in_ready, out_valid, sat_flag;
    logic [11:0] sum_out;
    logic [2:0]  count;

    logic        w_in_valid, w_out_ready;
    logic [15:0] w_tout_acc;
    logic        w_in_ready, w_out_valid, w_sat_flag;
    logic [11:0] w_sum_out;
    logic [2:0]  w_count;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [11:0] exp_q[$];
    logic        m_sat;

    mac_out_buffer #(.ACC_W(16), .OUT_W(12), .DEPTH(4), .SAT_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .tout_acc(tout_acc),
        .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
        .count(count), .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    mac_out_buffer #(.ACC_W(16), .OUT_W(12), .DEPTH(4), .SAT_EN(0)) dut_wrap (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .tout_acc(w_tout_acc),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .sum_out(w_sum_out),
        .count(w_count), .sat_flag(w_sat_flag), .sat_clr(1'b0)
    );

    function automatic logic is_clamped(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (s > 2047) || (s < -2048);
    endfunction

    function automatic logic [11:0] conv(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s > 2047)  return 12'h7FF;
        if (s < -2048) return 12'h800;
        return v[11:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check registered outputs against the scoreboard, clock once, then update the model.
    task automatic tick();
        int          n;
        logic        do_push, do_pop;
        logic [11:0] head;
        n       = exp_q.size();
        head    = (n != 0) ? exp_q[0] : 12'h000;
        check("in_ready",  32'(in_ready),  32'(n != 4));
        check("out_valid", 32'(out_valid), 32'(n != 0));
        check("count",     32'(count),     32'(n));
        check("sum_out",   32'(sum_out),   32'(head));
        do_push = in_valid && (n != 4) && !flush;
        do_pop  = out_ready && (n != 0) && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(conv(tout_acc));
        end
        if (do_push && is_clamped(tout_acc)) m_sat = 1'b1;
        else if (sat_clr)                    m_sat = 1'b0;
        check("sat_flag", 32'(sat_flag), 32'(m_sat));
    endtask

    task automatic push_word(input logic [15:0] v);
        in_valid = 1'b1;
        tout_acc = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        tout_acc = '0; w_in_valid = 1'b0; w_out_ready = 1'b0; w_tout_acc = '0;
        m_sat = 1'b0;

        // Reset state
        #2;
        check("rst_count",     32'(count),     32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_sum_out",   32'(sum_out),   32'(0));
        check("rst_sat_flag",  32'(sat_flag),  32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single push, one-cycle latency, then drain
        push_word(16'h0123);
        tick();
        drain(2);

        // Saturation both ways; flag sticky until sat_clr, set wins over clear
        push_word(16'h0900);
        push_word(16'hF000);
        tick();
        drain(3);
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        tick();
        sat_clr = 1'b1;
        push_word(16'h7FFF);
        sat_clr = 1'b0;
        drain(2);

        // Wrapping instance: low bits kept, flag never set
        w_in_valid = 1'b1; w_tout_acc = 16'h0900;
        @(posedge clk); #1;
        w_tout_acc = 16'hF000;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        check("wrap_count",  32'(w_count),    32'(2));
        check("wrap_word0",  32'(w_sum_out),  32'(12'h900));
        check("wrap_sat0",   32'(w_sat_flag), 32'(0));
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        check("wrap_word1",  32'(w_sum_out),  32'(12'h000));
        check("wrap_sat1",   32'(w_sat_flag), 32'(0));
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        check("wrap_empty",  32'(w_out_valid), 32'(0));
        check("wrap_sum0",   32'(w_sum_out),   32'(0));

        // Fill to full, fifth push rejected, then drain in order with pointer wrap
        push_word(16'h0011);
        push_word(16'h0022);
        push_word(16'h0033);
        push_word(16'h0044);
        push_word(16'h0055);
        drain(5);

        // Steady push+pop at count=2
        push_word(16'h0101);
        push_word(16'h0102);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tout_acc = 16'(16'h0200 + i);
            tick();
        end
        in_valid = 1'b0;
        drain(3);

        // Flush with count=3 and a simultaneous push
        push_word(16'h0301);
        push_word(16'h0302);
        push_word(16'h0303);
        flush    = 1'b1;
        in_valid = 1'b1;
        tout_acc = 16'h0555;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        drain(1);

        // Asynchronous reset between edges with count=2 and sat_flag set
        push_word(16'h9000);
        push_word(16'h0042);
        #2 rst = 1'b1;
        #1;
        check("arst_count",     32'(count),     32'(0));
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_in_ready",  32'(in_ready),  32'(1));
        check("arst_sum_out",   32'(sum_out),   32'(0));
        check("arst_sat_flag",  32'(sat_flag),  32'(0));
        #1 rst = 1'b0;
        exp_q.delete();
        m_sat = 1'b0;
        push_word(16'h0123);
        tick();
        drain(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
